// File: rtl/ysyx_22041211_defs.sv
// Shared definitions for the writeback unit: FSM state encoding and load-type codes.
package ysyx_22041211_defs;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } wbu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/ysyx_22041211_wbu_if.sv
// Execute-to-writeback handshake bundle; the execute stage is the master.
interface ysyx_22041211_wbu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  exu_valid;
  logic                  exu_ready;
  logic [4:0]            exu_rd;
  logic                  exu_wen;
  logic                  exu_is_load;
  logic [2:0]            exu_funct3;
  logic [DATA_WIDTH-1:0] exu_result;

  modport master (
    output exu_valid, exu_rd, exu_wen, exu_is_load, exu_funct3, exu_result,
    input  exu_ready
  );

  modport slave (
    input  exu_valid, exu_rd, exu_wen, exu_is_load, exu_funct3, exu_result,
    output exu_ready
  );
endinterface

// File: rtl/ysyx_22041211_load_ext.sv
// Combinational load data extraction: picks byte/half from an aligned word and extends it.
module ysyx_22041211_load_ext
  import ysyx_22041211_defs::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            i_funct3,
  input  logic [1:0]            i_addr,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Misaligned halfwords fall back to the aligned half containing the address.
  assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
  assign w_half = i_rdata[{i_addr[1], 4'b0000} +: 16];

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      F3_LBU:  o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      F3_LHU:  o_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_wbu.sv
// Writeback unit: accepts one EXU result at a time, waits for load data if needed,
// and retires it to the register file with a one-cycle commit pulse.
module ysyx_22041211_wbu
  import ysyx_22041211_defs::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_22041211_wbu_if.slave    exu,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_regWrite,
  output logic [4:0]            rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  wb_busy,
  output logic [4:0]            wb_busy_rd,
  output logic                  commit
);

  wbu_state_t            r_state;
  wbu_state_t            w_next_state;
  logic [4:0]            r_rd;
  logic                  r_wen;
  logic [2:0]            r_funct3;
  logic [1:0]            r_addr_lo;
  logic [4:0]            r_rf_rd;
  logic [DATA_WIDTH-1:0] r_rf_wdata;
  logic [DATA_WIDTH-1:0] w_ext_data;
  logic                  w_xfer;
  logic                  w_commit;

  ysyx_22041211_load_ext #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_ext (
    .i_funct3(r_funct3),
    .i_addr  (r_addr_lo),
    .i_rdata (mem_rdata),
    .o_data  (w_ext_data)
  );

  // Gating with rst keeps the reset cycle free of handshakes and register writes.
  assign exu.exu_ready = (r_state == IDLE) && rst;
  assign w_xfer        = exu.exu_valid && exu.exu_ready;
  assign w_commit      = (r_state == COMMIT) && rst;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // NOTE: the default assignment comes first so no path through always_comb infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_xfer) w_next_state = exu.exu_is_load ? WAIT_MEM : COMMIT;
      WAIT_MEM: if (mem_rvalid) w_next_state = COMMIT;
      COMMIT:   w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Output registers only change on entry to COMMIT, so rf_rd/rf_wdata hold between retirements.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd       <= '0;
      r_wen      <= 1'b0;
      r_funct3   <= '0;
      r_addr_lo  <= '0;
      r_rf_rd    <= '0;
      r_rf_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_rd  <= exu.exu_rd;
            r_wen <= exu.exu_wen;
            if (exu.exu_is_load) begin
              r_funct3  <= exu.exu_funct3;
              r_addr_lo <= exu.exu_result[1:0];
            end else begin
              r_rf_rd    <= exu.exu_rd;
              r_rf_wdata <= exu.exu_result;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            r_rf_rd    <= r_rd;
            r_rf_wdata <= w_ext_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign commit      = w_commit;
  assign rf_regWrite = w_commit && r_wen && (r_rd != 5'd0);
  assign rf_rd       = r_rf_rd;
  assign rf_wdata    = r_rf_wdata;
  assign wb_busy     = (r_state == WAIT_MEM);
  assign wb_busy_rd  = (wb_busy && r_wen) ? r_rd : 5'd0;

endmodule

// File: tb/tb_ysyx_22041211_wbu.sv
// Randomized bench for the writeback unit, checked every cycle against a transaction-level model.
module tb_ysyx_22041211_wbu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rf_regWrite;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        wb_busy;
  logic [4:0]  wb_busy_rd;
  logic        commit;

  ysyx_22041211_wbu_if #(.DATA_WIDTH(32)) exu_if ();

  ysyx_22041211_wbu #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .exu        (exu_if),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rf_regWrite(rf_regWrite),
    .rf_rd      (rf_rd),
    .rf_wdata   (rf_wdata),
    .wb_busy    (wb_busy),
    .wb_busy_rd (wb_busy_rd),
    .commit     (commit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: expected retirements plus the cycle windows where the unit is occupied / waiting on memory.
  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          out_lo = 0, out_hi = -1;
  int          busy_lo = 0, busy_hi = -1;
  logic [4:0]  busy_rd = '0;
  logic [4:0]  held_rd = '0;
  logic [31:0] held_wdata = '0;
  bit          chk_en = 0;
  int          commit_cnt = 0;
  int          busy_cnt = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Per-cycle comparison, sampled mid-cycle after the driver has updated its inputs.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      logic exp_busy;
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      check("exu_ready", exu_if.exu_ready, rst && !((cyc >= out_lo) && (cyc <= out_hi)));
      check("wb_busy", wb_busy, exp_busy);
      check("wb_busy_rd", wb_busy_rd, exp_busy ? busy_rd : 5'd0);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("commit", commit, rst);
        check("rf_regWrite", rf_regWrite, e.we && rst);
        check("rf_rd", rf_rd, e.rd);
        check("rf_wdata", rf_wdata, e.data);
        held_rd    = e.rd;
        held_wdata = e.data;
      end else begin
        check("commit_idle", commit, 0);
        check("rf_regWrite_idle", rf_regWrite, 0);
        check("rf_rd_hold", rf_rd, held_rd);
        check("rf_wdata_hold", rf_wdata, held_wdata);
      end
      if (commit === 1'b1) commit_cnt++;
      if (wb_busy === 1'b1) busy_cnt++;
    end
  end

  task automatic idle(input int n);
    logic [31:0] rnd;
    repeat (n) begin
      rnd = $urandom;
      exu_if.exu_valid   = 1'b0;
      exu_if.exu_rd      = rnd[4:0];
      exu_if.exu_is_load = rnd[5];
      mem_rvalid         = rnd[6];
      mem_rdata          = $urandom;
      @(negedge clk);
    end
  endtask

  task automatic issue_alu(input logic [4:0] rd, input logic wen, input logic [31:0] data,
                           input bit keep, input bit use_lit, input logic [31:0] lit);
    exp_t        e;
    logic [31:0] rnd;
    int          k;
    k   = cyc + 1;
    rnd = $urandom;
    exu_if.exu_valid   = 1'b1;
    exu_if.exu_is_load = 1'b0;
    exu_if.exu_rd      = rd;
    exu_if.exu_wen     = wen;
    exu_if.exu_funct3  = rnd[2:0];
    exu_if.exu_result  = data;
    mem_rvalid         = rnd[3];
    e.cyc = k; e.rd = rd; e.we = wen && (rd != 5'd0); e.data = data;
    exp_q.push_back(e);
    out_lo = k; out_hi = k;
    @(negedge clk);
    if (!keep) exu_if.exu_valid = 1'b0;
    mem_rvalid = rnd[4];
    if (use_lit) begin
      #2;
      check("lit_alu_commit", commit, 1);
      check("lit_alu_wdata", rf_wdata, lit);
    end
    @(negedge clk);
  endtask

  task automatic issue_load(input logic [4:0] rd, input logic wen, input logic [2:0] f3,
                            input logic [1:0] a, input logic [31:0] word, input int d,
                            input bit use_lit, input logic [31:0] lit);
    exp_t        e;
    logic [31:0] rnd;
    int          k;
    k   = cyc + 1;
    rnd = $urandom;
    exu_if.exu_valid   = 1'b1;
    exu_if.exu_is_load = 1'b1;
    exu_if.exu_rd      = rd;
    exu_if.exu_wen     = wen;
    exu_if.exu_funct3  = f3;
    exu_if.exu_result  = {rnd[31:2], a};
    e.cyc = k + d; e.rd = rd; e.we = wen && (rd != 5'd0); e.data = ref_load(f3, a, word);
    exp_q.push_back(e);
    out_lo = k; out_hi = k + d;
    busy_lo = k; busy_hi = k + d - 1;
    busy_rd = wen ? rd : 5'd0;
    @(negedge clk);
    exu_if.exu_valid = 1'b0;
    for (int j = 1; j < d; j++) begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      @(negedge clk);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = word;
    @(negedge clk);
    rnd        = $urandom;
    mem_rvalid = rnd[0];
    mem_rdata  = $urandom;
    if (use_lit) begin
      #2;
      check("lit_load_commit", commit, 1);
      check("lit_load_wdata", rf_wdata, lit);
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int          c0;
    logic [31:0] rnd;
    exu_if.exu_valid   = 1'b0;
    exu_if.exu_rd      = '0;
    exu_if.exu_wen     = 1'b0;
    exu_if.exu_is_load = 1'b0;
    exu_if.exu_funct3  = '0;
    exu_if.exu_result  = '0;

    // Reset held for two edges; checking starts after the first one.
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    rst = 1'b1;
    idle(1);

    // Pin the reference extension model with hand-computed values.
    check("model_lbu", ref_load(3'b100, 2'd1, 32'h0000_AB00), 32'h0000_00AB);
    check("model_lw_mis", ref_load(3'b010, 2'd3, 32'hDEAD_BEEF), 32'hDEAD_BEEF);
    check("model_f3_111", ref_load(3'b111, 2'd2, 32'h8765_4321), 32'h8765_4321);
    check("model_lh_lo", ref_load(3'b001, 2'd1, 32'h0000_F00D), 32'hFFFF_F00D);

    // Directed cases.
    issue_alu(5'd5, 1'b1, 32'h1234_5678, 0, 1, 32'h1234_5678);
    idle(1);
    c0 = busy_cnt;
    issue_load(5'd9, 1'b1, 3'b000, 2'd3, 32'h80FF_0000, 3, 1, 32'hFFFF_FF80);
    check("lb_busy_cycles", busy_cnt - c0, 3);
    issue_load(5'd10, 1'b1, 3'b101, 2'd2, 32'h8001_1234, 2, 1, 32'h0000_8001);
    issue_load(5'd11, 1'b1, 3'b001, 2'd2, 32'h8001_1234, 1, 1, 32'hFFFF_8001);
    c0 = commit_cnt;
    issue_alu(5'd0, 1'b1, 32'hCAFE_F00D, 0, 0, 0);
    check("rd0_commit_count", commit_cnt - c0, 1);
    issue_load(5'd0, 1'b1, 3'b010, 2'd0, 32'h1111_2222, 2, 1, 32'h1111_2222);
    issue_load(5'd7, 1'b0, 3'b100, 2'd0, 32'h0000_00F5, 2, 1, 32'h0000_00F5);

    // Three ALU ops with exu_valid held high: one accepted every other cycle.
    c0 = commit_cnt;
    issue_alu(5'd1, 1'b1, 32'h0000_0001, 1, 0, 0);
    issue_alu(5'd2, 1'b1, 32'h0000_0002, 1, 0, 0);
    issue_alu(5'd3, 1'b1, 32'h0000_0003, 0, 0, 0);
    #2;
    check("b2b_commits_in_6", commit_cnt - c0, 3);
    @(negedge clk);

    // Reset while waiting on memory, with the load data arriving in the reset cycle.
    exu_if.exu_valid   = 1'b1;
    exu_if.exu_is_load = 1'b1;
    exu_if.exu_rd      = 5'd12;
    exu_if.exu_wen     = 1'b1;
    exu_if.exu_funct3  = 3'b010;
    exu_if.exu_result  = 32'h0000_1000;
    out_lo  = cyc + 1; out_hi  = cyc + 2;
    busy_lo = cyc + 1; busy_hi = cyc + 2;
    busy_rd = 5'd12;
    @(negedge clk);
    exu_if.exu_valid = 1'b0;
    mem_rvalid       = 1'b0;
    @(negedge clk);
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5A5A_5A5A;
    @(negedge clk);
    rst        = 1'b1;
    mem_rvalid = 1'b0;
    held_rd    = '0;
    held_wdata = '0;
    #2;
    check("rst_busy_cleared", wb_busy, 0);
    check("rst_no_write", rf_regWrite, 0);
    check("rst_wdata_cleared", rf_wdata, 0);
    check("rst_ready_back", exu_if.exu_ready, 1);
    @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      rnd = $urandom;
      idle(int'(rnd[1:0]) % 3);
      rnd = $urandom;
      if (rnd[0])
        issue_load((rnd[3:1] == 3'd0) ? 5'd0 : rnd[8:4], rnd[10:9] != 2'd0, rnd[13:11],
                   rnd[15:14], $urandom, int'(rnd[17:16]) + 1, 0, 0);
      else
        issue_alu((rnd[3:1] == 3'd0) ? 5'd0 : rnd[8:4], rnd[10:9] != 2'd0, $urandom,
                  rnd[18], 0, 0);
    end
    idle(2);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_22041211_wbu.md
YSYX_22041211_WBU -- requirements
Module: ysyx_22041211_wbu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register data width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-low reset, sampled on clk rising edge.
REQ-004 SHALL have port exu_valid, input, 1: execute stage offers a result.
REQ-005 SHALL have port exu_ready, output, 1: WBU accepts the offer this cycle.
REQ-006 SHALL have port exu_rd, input, 5: destination register index.
REQ-007 SHALL have port exu_wen, input, 1: instruction writes rd.
REQ-008 SHALL have port exu_is_load, input, 1: result comes from memory.
REQ-009 SHALL have port exu_funct3, input, 3: load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-010 SHALL have port exu_result, input, DATA_WIDTH: ALU result, or byte address for loads.
REQ-011 SHALL have port mem_rvalid, input, 1: load data is valid.
REQ-012 SHALL have port mem_rdata, input, DATA_WIDTH: word-aligned load data.
REQ-013 SHALL have port rf_regWrite, output, 1: register-file write enable.
REQ-014 SHALL have port rf_rd, output, 5: register-file write index.
REQ-015 SHALL have port rf_wdata, output, DATA_WIDTH: register-file write data.
REQ-016 SHALL have port wb_busy, output, 1: a load is pending writeback.
REQ-017 SHALL have port wb_busy_rd, output, 5: rd of the pending load; 0 when not busy.
REQ-018 SHALL have port commit, output, 1: one-cycle pulse per retired instruction.

Function
REQ-019 SHALL implement the FSM states IDLE, WAIT_MEM and COMMIT.
REQ-020 SHALL assert exu_ready only in IDLE; a transfer occurs when exu_valid and exu_ready are both high.
REQ-021 SHALL move a non-load transfer from IDLE to COMMIT, latching rd, wen and result; this is one-cycle latency.
REQ-022 SHALL move a load transfer from IDLE to WAIT_MEM, latching rd, wen, funct3 and addr[1:0].
REQ-023 SHALL, in WAIT_MEM, hold until mem_rvalid, then latch the extended load data and move to COMMIT.
REQ-024 SHALL ignore mem_rvalid outside WAIT_MEM.
REQ-025 SHALL, in COMMIT, drive rf_regWrite = wen AND (rd != 0), drive rf_rd and rf_wdata from the latches, pulse commit, and return to IDLE.
REQ-026 SHALL hold rf_regWrite at 0 in IDLE and WAIT_MEM; rf_rd/rf_wdata hold their last values.
REQ-027 SHALL select the load byte by mem_rdata[8*addr[1:0] +: 8] and the halfword by mem_rdata[16*addr[1] +: 16].
REQ-028 SHALL sign-extend for LB and LH and zero-extend for LBU and LHU.
REQ-029 SHALL pass LW data unchanged; misaligned LW/LH SHALL use the aligned word/half without fault.
REQ-030 SHALL treat funct3 011, 110 and 111 as LW.
REQ-031 SHALL drive wb_busy high exactly while in WAIT_MEM, with wb_busy_rd = latched rd if wen, else 0.
REQ-032 SHALL, for a load with wen = 0 or rd = 0, still wait for mem_rvalid and still pulse commit.
REQ-033 SHALL give a throughput of at most one instruction per 2 cycles (IDLE plus COMMIT); no back-to-back acceptance.

Reset
REQ-034 SHALL, when rst = 0 at a clk edge, enter IDLE and clear rf_regWrite, rf_rd, rf_wdata, commit, wb_busy, wb_busy_rd and all latches to 0.
REQ-035 SHALL abort any pending operation on reset mid-WAIT_MEM or mid-COMMIT, with no register write in the reset cycle.
REQ-036 SHALL keep exu_ready at 0 during reset; it rises in the first cycle after rst returns to 1.

Structure
REQ-037 SHALL place the FSM state encoding (2 bits) and the funct3 load-type constants in the shared package ysyx_22041211_defs.
REQ-038 SHALL place the load-extension logic in the sub-module ysyx_22041211_load_ext (funct3, addr[1:0], rdata in; extended data out, combinational).
REQ-039 SHALL connect rf_regWrite, rf_rd and rf_wdata directly to the register file's regWrite, rd and wdata inputs.

Verification
REQ-040 SHALL test: ALU op rd = 5, result 0x1234_5678 -> commit one cycle later, rf_regWrite = 1, rf_rd = 5, rf_wdata = 0x1234_5678.
REQ-041 SHALL test: LB at addr 0x...3, mem_rdata 0x80FF_0000 returned 3 cycles later -> wb_busy = 1 and wb_busy_rd = rd for 3 cycles, then rf_wdata = 0xFFFF_FF80.
REQ-042 SHALL test: LHU at addr 0x...2, mem_rdata 0x8001_1234 -> rf_wdata = 0x0000_8001; LH at the same address -> 0xFFFF_8001.
REQ-043 SHALL test: ALU op to rd = 0 with wen = 1 -> commit pulses, rf_regWrite stays 0.
REQ-044 SHALL test: rst = 0 asserted in WAIT_MEM with mem_rvalid arriving in the same cycle -> no write, state IDLE, wb_busy = 0 next cycle.
REQ-045 SHALL test: exu_valid held high for 3 ALU ops -> exu_ready alternates 1/0 and produces exactly 3 commit pulses in 6 cycles.
